// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencing front/back end for the 32/16 iterative divider cores.
// Accepts a request, strips operand signs, launches the core with a one-cycle
// start, waits (with a timeout) for the core's ready pulse, sign-corrects the
// result and holds it until the consumer takes it.
// Optional feature macro: DIV_SIGNED_EN (signed divide support). When it is
// undefined every divide is unsigned and no negate logic is built.
module div_seq_ctrl #(
    parameter int unsigned CORE_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_signed,
    input  logic [31:0] in_a,
    input  logic [15:0] in_b,
    output logic [31:0] core_a,
    output logic [15:0] core_b,
    output logic        core_start,
    input  logic        core_busy,
    input  logic        core_ready,
    input  logic [31:0] core_q,
    input  logic [15:0] core_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_q,
    output logic [15:0] out_r,
    output logic        out_div0,
    output logic        out_err
);

    localparam int CW = $clog2(CORE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FIXUP  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   a_q, a_d;      // dividend magnitude, drives core_a
    logic [15:0]   b_q, b_d;      // divisor magnitude, drives core_b
    logic [31:0]   q_q, q_d;      // raw core quotient, then final quotient
    logic [15:0]   r_q, r_d;      // raw core remainder, then final remainder
    logic          div0_q, div0_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   mag_a;
    logic [15:0]   mag_b;

`ifdef DIV_SIGNED_EN
    logic          neg_q_q, neg_q_d;
    logic          neg_r_q, neg_r_d;
    logic          sa, sb;

    // Operand sign extraction and two's-complement magnitude
    always_comb begin
        sa    = in_signed & in_a[31];
        sb    = in_signed & in_b[15];
        mag_a = sa ? (~in_a + 32'd1) : in_a;
        mag_b = sb ? (~in_b + 16'd1) : in_b;
    end
`else
    // Unsigned-only build: operands go to the core untouched
    logic unused_signed;
    assign unused_signed = in_signed;
    assign mag_a         = in_a;
    assign mag_b         = in_b;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        q_d        = q_q;
        r_d        = r_q;
        div0_d     = div0_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        core_start = 1'b0;
`ifdef DIV_SIGNED_EN
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d    = mag_a;
                    b_d    = mag_b;
                    div0_d = (in_b == 16'd0);
                    err_d  = 1'b0;
`ifdef DIV_SIGNED_EN
                    neg_q_d = sa ^ sb;
                    neg_r_d = sa;
`endif
                    if (in_b == 16'd0) begin
                        // Divide-by-zero is answered locally; the core never runs
                        q_d     = 32'hFFFF_FFFF;
                        r_d     = in_a[15:0];
                        state_d = DONE;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                if (!core_busy) begin
                    core_start = 1'b1;
                    cnt_d      = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (core_ready) begin
                    q_d     = core_q;
                    r_d     = core_r;
                    state_d = FIXUP;
                end else if (cnt_q == CW'(CORE_TIMEOUT - 1)) begin
                    // Core never answered: report an error with a zero result
                    err_d   = 1'b1;
                    q_d     = '0;
                    r_d     = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIXUP: begin
`ifdef DIV_SIGNED_EN
                if (neg_q_q) q_d = ~q_q + 32'd1;
                if (neg_r_q) r_d = ~r_q + 16'd1;
`endif
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef DIV_SIGNED_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    // in_ready is masked while reset is held so every output reads 0 in reset
    assign in_ready  = (state_q == IDLE) & ~reset;
    assign out_valid = (state_q == DONE);
    assign core_a    = a_q;
    assign core_b    = b_q;
    assign out_q     = q_q;
    assign out_r     = r_q;
    assign out_div0  = div0_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: behavioural divider core plus an
// arithmetic reference model; directed cases followed by random requests.
module tb_div_seq_ctrl;

    localparam int TO = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_signed;
    logic [31:0] in_a;
    logic [15:0] in_b;
    logic [31:0] core_a;
    logic [15:0] core_b;
    logic        core_start, core_busy, core_ready;
    logic [31:0] core_q;
    logic [15:0] core_r;
    logic        out_valid, out_ready;
    logic [31:0] out_q;
    logic [15:0] out_r;
    logic        out_div0, out_err;

    int n_tests = 0;
    int n_fail  = 0;

    // core model state
    int          cd = 0;
    int          lat = 1;
    bit          hold_ready = 1'b0;
    int          n_start = 0;
    int          bad_double = 0;
    int          bad_busy = 0;
    bit          prev_start = 1'b0;
    logic [31:0] st_a = '0;
    logic [15:0] st_b = '0;
    logic [31:0] tmp_r;

    div_seq_ctrl #(.CORE_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_a(in_a), .in_b(in_b),
        .core_a(core_a), .core_b(core_b), .core_start(core_start),
        .core_busy(core_busy), .core_ready(core_ready),
        .core_q(core_q), .core_r(core_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_div0(out_div0), .out_err(out_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit integers
    function automatic void ref_div(input logic [31:0] a, input logic [15:0] b, input logic s,
                                    output logic [31:0] q, output logic [15:0] r,
                                    output logic [31:0] ma, output logic [15:0] mb);
        bit     sg;
        longint la, lb, lq, lr, lma, lmb;
        sg = s;
`ifndef DIV_SIGNED_EN
        sg = 1'b0;
`endif
        la  = sg ? longint'({{32{a[31]}}, a}) : longint'({32'b0, a});
        lb  = sg ? longint'({{48{b[15]}}, b}) : longint'({48'b0, b});
        lma = (la < 0) ? -la : la;
        lmb = (lb < 0) ? -lb : lb;
        ma  = lma[31:0];
        mb  = lmb[15:0];
        if (b == 16'd0) begin
            q = 32'hFFFF_FFFF;
            r = a[15:0];
        end else begin
            lq = la / lb;
            lr = la % lb;
            q  = lq[31:0];
            r  = lr[15:0];
        end
    endfunction

    // Behavioural divider core: answers `lat` cycles after its start pulse
    initial begin
        core_ready = 1'b0;
        core_q     = '0;
        core_r     = '0;
        forever begin
            @(negedge clock);
            #1;
            core_ready = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && !hold_ready) begin
                    core_ready = 1'b1;
                    if (st_b == 16'd0) begin
                        core_q = '1;
                        core_r = '1;
                    end else begin
                        core_q = st_a / {16'b0, st_b};
                        tmp_r  = st_a % {16'b0, st_b};
                        core_r = tmp_r[15:0];
                    end
                end
            end
            if (core_start) begin
                n_start++;
                st_a = core_a;
                st_b = core_b;
                cd   = lat;
                if (prev_start) bad_double++;
                if (core_busy) bad_busy++;
            end
            prev_start = core_start;
        end
    end

    // One request end to end; to_mode withholds core_ready to force a timeout
    task automatic run_req(input logic [31:0] a, input logic [15:0] b, input logic s,
                           input int lat_i, input int busy_n, input int hold, input bit to_mode);
        logic [31:0] eq, ema;
        logic [15:0] er, emb;
        int          k, starts0, exp_k;
        bit          z;
        ref_div(a, b, s, eq, er, ema, emb);
        z = (b == 16'd0);
        @(negedge clock);
        chk("in_ready_idle", 32'(in_ready), 1);
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        lat = lat_i; hold_ready = to_mode; core_busy = 1'b0; out_ready = 1'b0;
        starts0 = n_start;
        @(negedge clock);
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 200) begin
            core_busy = (k <= busy_n);
            @(negedge clock);
            k++;
        end
        core_busy = 1'b0;
        if (z)            exp_k = 1;
        else if (to_mode) exp_k = busy_n + TO + 2;
        else              exp_k = busy_n + lat_i + 3;
        chk("latency", 32'(k), 32'(exp_k));
        chk("out_valid", 32'(out_valid), 1);
        chk("out_q", out_q, to_mode ? 32'd0 : eq);
        chk("out_r", 32'(out_r), to_mode ? 32'd0 : 32'(er));
        chk("out_div0", 32'(out_div0), 32'(z));
        chk("out_err", 32'(out_err), 32'(to_mode));
        chk("n_start", 32'(n_start - starts0), z ? 32'd0 : 32'd1);
        if (!z) begin
            chk("core_a_mag", st_a, ema);
            chk("core_b_mag", 32'(st_b), 32'(emb));
        end
        repeat (hold) begin
            @(negedge clock);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_q", out_q, to_mode ? 32'd0 : eq);
        end
        chk("no_bypass", 32'(in_ready), 0);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("released", 32'(out_valid), 0);
        chk("in_ready_after", 32'(in_ready), 1);
        hold_ready = 1'b0;
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [15:0] rb;
        reset = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
        core_busy = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_core_start", 32'(core_start), 0);
        chk("rst_out_q", out_q, 0);
        chk("rst_out_r", 32'(out_r), 0);
        chk("rst_flags", 32'({out_div0, out_err}), 0);
        chk("rst_core_ab", core_a | 32'(core_b), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("in_ready_post_rst", 32'(in_ready), 1);

        // directed cases
        run_req(32'h4c7f228a, 16'h6a0e, 1'b0, 32, 0, 5, 1'b0);
        chk("tp1_q", out_q, 32'h0000B8A6);
        chk("tp1_r", 32'(out_r), 32'h4D76);
        run_req(32'h55555555, 16'hFFFE, 1'b1, 32, 2, 1, 1'b0);
        run_req(32'hFFFFFFF9, 16'h0002, 1'b1, 10, 0, 0, 1'b0);
`ifdef DIV_SIGNED_EN
        chk("tp3_q", out_q, 32'hFFFFFFFD);
        chk("tp3_r", 32'(out_r), 32'hFFFF);
`else
        chk("tp3_q", out_q, 32'h7FFFFFFC);
        chk("tp3_r", 32'(out_r), 32'h0001);
`endif
        run_req(32'h12345678, 16'h0000, 1'b1, 5, 0, 2, 1'b0);
        chk("tp4_r", 32'(out_r), 32'h5678);
        run_req(32'h80000000, 16'hFFFF, 1'b1, 32, 0, 0, 1'b0);
        run_req(32'h80000000, 16'h8000, 1'b1, 7, 1, 0, 1'b0);
        run_req(32'hDEADBEEF, 16'h0001, 1'b0, 1, 0, 0, 1'b0);

        // core_ready withheld: timeout path
        run_req(32'h00001000, 16'h0003, 1'b0, 3, 1, 2, 1'b1);

        // reset in WAIT, then the aborted op's ready pulse arrives late
        @(negedge clock);
        in_a = 32'h0F0F0F0F; in_b = 16'h0033; in_signed = 1'b0; in_valid = 1'b1;
        lat = 20; hold_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("wrst_in_ready", 32'(in_ready), 0);
        chk("wrst_out_valid", 32'(out_valid), 0);
        chk("wrst_out_q", out_q, 0);
        chk("wrst_core_a", core_a, 0);
        chk("wrst_flags", 32'({out_div0, out_err, core_start}), 0);
        reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (out_valid || core_start || !in_ready) seen++;
        end
        chk("late_ready_ignored", 32'(seen), 0);
        chk("late_out_q", out_q, 0);

        // random requests
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            run_req(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(1, 32),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        chk("double_start", 32'(bad_double), 0);
        chk("start_while_busy", 32'(bad_busy), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
